// File: rtl/uart_frame_echo.sv
// Length-prefixed frame echo between UART RX/TX byte interfaces: HEADER, LEN, payload in; same out.
// Optional trailing XOR checksum byte when UART_FRAME_CSUM_EN is defined.
module uart_frame_echo #(
  parameter logic [7:0]  HEADER_BYTE    = 8'hAA,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 260_000,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  output logic       o_busy,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [7:0] o_drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_FRAME_CSUM_EN
  typedef enum logic [1:0] {StHunt, StLen, StData, StCsum} rx_state_e;
  typedef enum logic [2:0] {StTIdle, StTHdr, StTLen, StTData, StTWait, StTCsum} tx_state_e;
  localparam rx_state_e RxAfterData = StCsum;
  localparam tx_state_e TxAfterData = StTCsum;
`else
  typedef enum logic [1:0] {StHunt, StLen, StData} rx_state_e;
  typedef enum logic [2:0] {StTIdle, StTHdr, StTLen, StTData, StTWait} tx_state_e;
  localparam rx_state_e RxAfterData = StHunt;
  localparam tx_state_e TxAfterData = StTIdle;
`endif

  rx_state_e     rx_q, rx_d;
  tx_state_e     tx_q, tx_d, ret_q, ret_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [7:0]    rx_cnt_q, rx_cnt_d, drop_q, drop_d, rem_q, rem_d;
  logic [7:0]    tx_byte_q, tx_byte_d, send_byte;
  logic          aborted_q, aborted_d, ok_q, ok_d, err_q, err_d;
  logic          abort_set, tx_start, timeout, send;

`ifdef UART_FRAME_CSUM_EN
  logic [7:0] rx_csum_q, rx_csum_d, tx_csum_q, tx_csum_d;
  logic       csum_bad_q, csum_bad_d, csum_bad_set;
`endif

  // Payload FIFO; extra pointer bit distinguishes full from empty.
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop, push_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_rdata = fifo_mem[rd_ptr_q[AW-1:0]];
  assign fifo_pop   = (tx_q == StTData) && !i_tx_active && !fifo_empty;
  assign push_ok    = fifo_push && (!fifo_full || fifo_pop);

  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= i_rx_byte;
  end

  // Receive side: header hunt, length check, payload capture, idle timeout.
  always_comb begin
    rx_d      = rx_q;
    rx_cnt_d  = rx_cnt_q;
    drop_d    = drop_q;
    idle_d    = '0;
    tx_start  = 1'b0;
    fifo_push = 1'b0;
    abort_set = 1'b0;
    err_d     = 1'b0;
    timeout   = (rx_q != StHunt) && !i_rx_dv && (idle_q == TW'(TIMEOUT_CYCLES - 1));
`ifdef UART_FRAME_CSUM_EN
    rx_csum_d    = rx_csum_q;
    csum_bad_set = 1'b0;
`endif
    if (rx_q != StHunt && !i_rx_dv) idle_d = idle_q + TW'(1);
    unique case (rx_q)
      StHunt: begin
        if (i_rx_dv && i_rx_byte == HEADER_BYTE) begin
          if (tx_q == StTIdle) rx_d = StLen;
          else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
      end
      StLen: begin
        if (timeout) begin
          err_d = 1'b1;
          rx_d  = StHunt;
        end else if (i_rx_dv) begin
          if (i_rx_byte != 8'd0 && i_rx_byte <= 8'(MAX_LEN)) begin
            rx_cnt_d = i_rx_byte;
            tx_start = 1'b1;
            rx_d     = StData;
`ifdef UART_FRAME_CSUM_EN
            rx_csum_d = i_rx_byte;
`endif
          end else begin
            err_d = 1'b1;
            rx_d  = StHunt;
          end
        end
      end
      StData: begin
        fifo_push = i_rx_dv;
        if (timeout || (i_rx_dv && fifo_full && !fifo_pop)) begin
          err_d     = 1'b1;
          abort_set = 1'b1;
          rx_d      = StHunt;
        end else if (i_rx_dv) begin
          rx_cnt_d = rx_cnt_q - 8'd1;
`ifdef UART_FRAME_CSUM_EN
          rx_csum_d = rx_csum_q ^ i_rx_byte;
`endif
          if (rx_cnt_q == 8'd1) rx_d = RxAfterData;
        end
      end
`ifdef UART_FRAME_CSUM_EN
      StCsum: begin
        if (timeout || (i_rx_dv && i_rx_byte != rx_csum_q)) begin
          err_d        = 1'b1;
          csum_bad_set = 1'b1;
          rx_d         = StHunt;
        end else if (i_rx_dv) begin
          rx_d = StHunt;
        end
      end
`endif
      default: rx_d = StHunt;
    endcase
  end

  // Transmit side: one outstanding byte at a time, StTWait holds the state to resume into.
  always_comb begin
    tx_d      = tx_q;
    ret_d     = ret_q;
    rem_d     = rem_q;
    tx_byte_d = tx_byte_q;
    send      = 1'b0;
    send_byte = tx_byte_q;
    ok_d      = 1'b0;
    aborted_d = aborted_q | abort_set;
`ifdef UART_FRAME_CSUM_EN
    tx_csum_d  = tx_csum_q;
    csum_bad_d = csum_bad_q | csum_bad_set;
`endif
    unique case (tx_q)
      StTIdle: begin
        if (tx_start) begin
          tx_d  = StTHdr;
          rem_d = i_rx_byte;
        end
      end
      StTHdr: begin
        if (!i_tx_active) begin
          send      = 1'b1;
          send_byte = HEADER_BYTE;
          ret_d     = StTLen;
        end
      end
      StTLen: begin
        if (!i_tx_active) begin
          send      = 1'b1;
          send_byte = rem_q;
          ret_d     = StTData;
`ifdef UART_FRAME_CSUM_EN
          tx_csum_d = rem_q;
`endif
        end
      end
      StTData: begin
        // Pad only once RX has given up on the frame; otherwise wait for payload.
        if (!i_tx_active && (!fifo_empty || aborted_q)) begin
          send      = 1'b1;
          send_byte = fifo_empty ? PAD_BYTE : fifo_rdata;
          rem_d     = rem_q - 8'd1;
          ret_d     = (rem_q == 8'd1) ? TxAfterData : StTData;
`ifdef UART_FRAME_CSUM_EN
          tx_csum_d = tx_csum_q ^ send_byte;
`endif
        end
      end
`ifdef UART_FRAME_CSUM_EN
      StTCsum: begin
        // Hold until RX has judged the checksum so frame_ok reflects it.
        if (!i_tx_active && rx_q != StCsum) begin
          send      = 1'b1;
          send_byte = tx_csum_q;
          ret_d     = StTIdle;
        end
      end
`endif
      StTWait: begin
        if (i_tx_done) begin
          tx_d = ret_q;
          if (ret_q == StTIdle) begin
`ifdef UART_FRAME_CSUM_EN
            ok_d       = !aborted_q && !csum_bad_q;
            csum_bad_d = 1'b0;
`else
            ok_d       = !aborted_q;
`endif
            aborted_d  = 1'b0;
          end
        end
      end
      default: tx_d = StTIdle;
    endcase
    if (send) begin
      tx_d      = StTWait;
      tx_byte_d = send_byte;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_q      <= StHunt;
      tx_q      <= StTIdle;
      ret_q     <= StTIdle;
      idle_q    <= '0;
      rx_cnt_q  <= 8'd0;
      drop_q    <= 8'd0;
      rem_q     <= 8'd0;
      tx_byte_q <= 8'd0;
      aborted_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef UART_FRAME_CSUM_EN
      rx_csum_q  <= 8'd0;
      tx_csum_q  <= 8'd0;
      csum_bad_q <= 1'b0;
`endif
    end else begin
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      ret_q     <= ret_d;
      idle_q    <= idle_d;
      rx_cnt_q  <= rx_cnt_d;
      drop_q    <= drop_d;
      rem_q     <= rem_d;
      tx_byte_q <= tx_byte_d;
      aborted_q <= aborted_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      if (push_ok)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_FRAME_CSUM_EN
      rx_csum_q  <= rx_csum_d;
      tx_csum_q  <= tx_csum_d;
      csum_bad_q <= csum_bad_d;
`endif
    end
  end

  assign o_tx_dv     = send;
  assign o_tx_byte   = send ? send_byte : tx_byte_q;
  assign o_busy      = (rx_q != StHunt) || (tx_q != StTIdle);
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_drop_cnt  = drop_q;

endmodule
